// File: rtl/baud_tick_gen_if.sv
// ============================================================================
// Module  : baud_tick_gen_if
// Brief   : Control / tick bundle for the fractional baud timing generator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface baud_tick_gen_if #(
    parameter int ACC_WIDTH = 24
);
    logic                 enable;
    logic                 resync;
    logic                 inc_load;
    logic [ACC_WIDTH-1:0] inc_in;
    logic                 os_tick;
    logic                 bit_tick;
    logic                 mid_tick;
    logic [ACC_WIDTH-1:0] inc_cur;

    modport master (
        output enable, resync, inc_load, inc_in,
        input  os_tick, bit_tick, mid_tick, inc_cur
    );

    modport slave (
        input  enable, resync, inc_load, inc_in,
        output os_tick, bit_tick, mid_tick, inc_cur
    );
endinterface

`default_nettype wire

// File: rtl/baud_tick_gen.sv
// ============================================================================
// Module  : baud_tick_gen
// Brief   : Phase-accumulator baud generator with oversample, bit and mid-bit ticks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module baud_tick_gen #(
    parameter int CLKFREQ    = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int ACC_WIDTH  = 24
) (
    input  wire                   clk,
    input  wire                   rst,
    baud_tick_gen_if.slave        bus
);
    // Increment rounded to nearest: (BAUD*OS*2^W + CLKFREQ/2) / CLKFREQ
    localparam logic [63:0] c_INC_WIDE =
        (64'(BAUD) * 64'(OVERSAMPLE) * (64'd1 << ACC_WIDTH) + 64'(CLKFREQ) / 64'd2)
        / 64'(CLKFREQ);
    localparam logic [ACC_WIDTH-1:0] c_INC_DEFAULT = c_INC_WIDE[ACC_WIDTH-1:0];

    localparam int c_SUB_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [c_SUB_W-1:0] c_SUB_LAST = c_SUB_W'(OVERSAMPLE - 1);
    localparam logic [c_SUB_W-1:0] c_SUB_MID  = c_SUB_W'(OVERSAMPLE / 2 - 1);

    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_inc;
    logic [c_SUB_W-1:0]   r_sub;
    logic                 r_os;
    logic                 r_bit;
    logic                 r_mid;

    logic [ACC_WIDTH:0]   w_sum;
    logic                 w_carry;

    assign w_sum   = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_carry = w_sum[ACC_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_inc <= c_INC_DEFAULT;
            r_sub <= '0;
            r_os  <= 1'b0;
            r_bit <= 1'b0;
            r_mid <= 1'b0;
        end else begin
            // The increment reload is independent of resync/enable so the
            // rate can be changed while the phase keeps running.
            if (bus.inc_load) begin
                r_inc <= bus.inc_in;
            end

            if (bus.resync) begin
                r_acc <= '0;
                r_sub <= '0;
                r_os  <= 1'b0;
                r_bit <= 1'b0;
                r_mid <= 1'b0;
            end else if (bus.enable) begin
                r_acc <= w_sum[ACC_WIDTH-1:0];
                if (w_carry) begin
                    r_os  <= 1'b1;
                    r_bit <= (r_sub == c_SUB_LAST);
                    r_mid <= (r_sub == c_SUB_MID);
                    r_sub <= (r_sub == c_SUB_LAST) ? '0 : r_sub + 1'b1;
                end else begin
                    r_os  <= 1'b0;
                    r_bit <= 1'b0;
                    r_mid <= 1'b0;
                end
            end else begin
                r_os  <= 1'b0;
                r_bit <= 1'b0;
                r_mid <= 1'b0;
            end
        end
    end

    assign bus.os_tick  = r_os;
    assign bus.bit_tick = r_bit;
    assign bus.mid_tick = r_mid;
    assign bus.inc_cur  = r_inc;

endmodule

`default_nettype wire

// File: tb/tb_baud_tick_gen.sv
// ============================================================================
// Module  : tb_baud_tick_gen
// Brief   : Scoreboard bench for baud_tick_gen against an arithmetic phase model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_baud_tick_gen;
    localparam int  c_AW   = 24;
    localparam int  c_OS   = 16;
    localparam longint c_MOD = 64'd1 << c_AW;
    localparam logic [c_AW-1:0] c_DEF = 24'd25770;

    logic clk;
    logic rst;

    baud_tick_gen_if #(.ACC_WIDTH(c_AW)) bus ();

    baud_tick_gen #(
        .CLKFREQ    (100_000_000),
        .BAUD       (9600),
        .OVERSAMPLE (c_OS),
        .ACC_WIDTH  (c_AW)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            os;
        logic            bt;
        logic            md;
        logic [c_AW-1:0] inc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: phase as an integer fraction of one oversample period and
    // the number of oversample ticks seen since the last alignment point.
    longint m_phase;
    longint m_inc;
    longint m_os_count;
    logic   m_os, m_bt, m_md;

    task automatic cmp(input string name, input longint act, input longint want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic rs, input logic en,
                              input logic ld, input logic [c_AW-1:0] iv);
        longint total;
        longint nxt_inc;
        if (r) begin
            m_phase = 0; m_os_count = 0; m_inc = c_DEF;
            m_os = 0; m_bt = 0; m_md = 0;
        end else begin
            nxt_inc = ld ? longint'(iv) : m_inc;
            if (rs) begin
                m_phase = 0; m_os_count = 0;
                m_os = 0; m_bt = 0; m_md = 0;
            end else if (en) begin
                total   = m_phase + m_inc;
                m_phase = total % c_MOD;
                if (total >= c_MOD) begin
                    m_os_count++;
                    m_os = 1;
                    m_bt = (m_os_count % c_OS) == 0;
                    m_md = (m_os_count % c_OS) == c_OS / 2;
                end else begin
                    m_os = 0; m_bt = 0; m_md = 0;
                end
            end else begin
                m_os = 0; m_bt = 0; m_md = 0;
            end
            m_inc = nxt_inc;
        end
    endtask

    // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
    task automatic drive(input logic r, input logic rs, input logic en,
                         input logic ld, input logic [c_AW-1:0] iv);
        exp_t e;
        @(negedge clk);
        rst          = r;
        bus.resync   = rs;
        bus.enable   = en;
        bus.inc_load = ld;
        bus.inc_in   = iv;
        model_step(r, rs, en, ld, iv);
        e.os = m_os; e.bt = m_bt; e.md = m_md; e.inc = c_AW'(m_inc);
        exp_q.push_back(e);
    endtask

    // Monitor: the DUT presents a fresh output set after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("os_tick",  longint'(bus.os_tick),  longint'(e.os));
                cmp("bit_tick", longint'(bus.bit_tick), longint'(e.bt));
                cmp("mid_tick", longint'(bus.mid_tick), longint'(e.md));
                cmp("inc_cur",  longint'(bus.inc_cur),  longint'(e.inc));
            end
        end
    end

    function automatic logic [c_AW-1:0] pick_inc();
        case ($urandom_range(0, 7))
            0:       return 24'h40_0000;
            1:       return 24'h20_0000;
            2:       return c_DEF;
            3:       return 24'h00_0000;
            4:       return 24'hFF_FFFF;
            5:       return c_AW'($urandom_range(24'h80_0000, 24'hFF_FFFE));
            default: return c_AW'($urandom_range(1, 24'h7F_FFFF));
        endcase
    endfunction

    initial begin
        int     os_cnt;
        int     bit_cnt;
        longint n_cyc;
        logic   rnd_rst, rnd_rs, rnd_en, rnd_ld;

        rst = 1'b1; bus.enable = 1'b1; bus.resync = 1'b0;
        bus.inc_load = 1'b0; bus.inc_in = '0;
        m_phase = 0; m_inc = c_DEF; m_os_count = 0;
        m_os = 0; m_bt = 0; m_md = 0;

        // Reset held three clocks with enable asserted.
        repeat (3) drive(1, 0, 1, 0, '0);

        // Exact rate with a simultaneous load and resync, then a mid-bit resync.
        drive(0, 1, 1, 1, 24'h40_0000);
        repeat (150) drive(0, 0, 1, 0, '0);
        drive(0, 1, 1, 0, '0);
        repeat (140) drive(0, 0, 1, 0, '0);

        // Enable gap mid-bit, then live reload to the half rate.
        repeat (100) drive(0, 0, 0, 0, '0);
        repeat (70) drive(0, 0, 1, 0, '0);
        drive(0, 0, 1, 1, 24'h20_0000);
        repeat (200) drive(0, 0, 1, 0, '0);

        // Randomized control traffic over a mix of increments.
        for (int seg = 0; seg < 40; seg++) begin
            drive(0, $urandom_range(0, 1) == 1, 1, 1, pick_inc());
            for (int k = 0; k < 500; k++) begin
                rnd_rst = ($urandom_range(0, 999) < 2);
                rnd_rs  = ($urandom_range(0, 99) == 0);
                rnd_en  = ($urandom_range(0, 9) != 0);
                rnd_ld  = ($urandom_range(0, 199) == 0);
                drive(rnd_rst, rnd_rs, rnd_en, rnd_ld, pick_inc());
            end
        end

        // Long run at the default increment: tick counts follow floor(N*inc/2^W).
        n_cyc   = 40000;
        os_cnt  = 0;
        bit_cnt = 0;
        drive(1, 0, 1, 0, '0);
        for (longint k = 0; k <= n_cyc; k++) begin
            drive(0, 0, 1, 0, '0);
            os_cnt  += int'(bus.os_tick);
            bit_cnt += int'(bus.bit_tick);
        end
        cmp("os_count_default",  longint'(os_cnt),  (n_cyc * longint'(c_DEF)) / c_MOD);
        cmp("bit_count_default", longint'(bit_cnt), ((n_cyc * longint'(c_DEF)) / c_MOD) / c_OS);

        repeat (3) @(negedge clk);
        cmp("scoreboard_drained", longint'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
